// File: rtl/trigger_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_pkg
//  Description : Shared types and helpers for the multi-stage trigger
//                sequencer: FSM state encoding, default stage-index width
//                and the zero-means-one occurrence count helper.
//  Revision    : 1.0  initial release
// ============================================================================
package trigger_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Stage count of the default build and the matching index width.
   // Modules with a different STN derive their own index width locally.
   localparam int STN_DEFAULT = 4;
   localparam int STW         = $clog2(STN_DEFAULT);

   // A programmed occurrence count of 0 behaves as 1, so a stage always
   // needs at least one matching sample to complete. Counts up to 32 bits.
   function automatic logic [31:0] max1(input logic [31:0] cnt);
      return (cnt == 32'd0) ? 32'd1 : cnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_sequencer_match.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_stage_match
//  Description : Combinational event matcher for one sequencer stage.
//                OR mode : any masked event bit set.
//                AND mode: every masked event bit set.
//                An all-zero mask never matches in either mode.
//  Ports       : msk   [CMN] stage event mask
//                mod         combine mode (0 = OR, 1 = AND)
//                evt   [CMN] comparator event bits
//                match       stage condition satisfied
//  Revision    : 1.0  initial release
// ============================================================================
module trigger_stage_match #(
   parameter int CMN = 4
) (
   input  logic [CMN-1:0] msk,
   input  logic           mod,
   input  logic [CMN-1:0] evt,
   output logic           match
);

   logic [CMN-1:0] w_masked;
   logic           w_any;
   logic           w_all;

   assign w_masked = evt & msk;
   assign w_any    = |w_masked;
   assign w_all    = (w_masked == msk);

   // Gate with |msk so an empty mask cannot satisfy AND mode trivially.
   assign match = (|msk) & (mod ? w_all : w_any);

endmodule
`default_nettype wire

// File: rtl/trigger_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_sequencer
//  Description : Multi-stage trigger controller for the logic-analyzer
//                capture path. Walks up to STN stages; each stage waits for
//                a masked AND/OR combination of comparator events to occur a
//                programmed number of times. Completing the last stage emits
//                a one-cycle trigger pulse.
//  Options     : TRIGGER_SEQUENCER_TIMEOUT_EN - adds cfg_tmo / sts_tmo and a
//                per-stage timeout that returns stages >= 1 to stage 0.
//  Ports       : clk, rst (async, active-high)
//                ctl_arm / ctl_abort          control pulses (abort wins)
//                cfg_msk/mod/cnt/lst [/tmo]   per-stage configuration
//                evt_vld, evt_dat             comparator event sample
//                sts_run, sts_stg, sts_cnt    sequencer status
//                trg_hit (pulse), trg_done (sticky since last arm)
//                [sts_tmo]                    one-cycle timeout pulse
//  Parameters  : STN 2..16 stages, CMN comparator inputs, CNW <= 32
//  Revision    : 1.0  initial release
// ============================================================================
module trigger_sequencer
   import trigger_pkg::*;
#(
   parameter int STN = 4,
   parameter int CMN = 4,
   parameter int CNW = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ctl_arm,
   input  logic                    ctl_abort,
   input  logic [STN*CMN-1:0]      cfg_msk,
   input  logic [STN-1:0]          cfg_mod,
   input  logic [STN*CNW-1:0]      cfg_cnt,
   input  logic [STN-1:0]          cfg_lst,
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
   input  logic [STN*CNW-1:0]      cfg_tmo,
   output logic                    sts_tmo,
`endif
   input  logic                    evt_vld,
   input  logic [CMN-1:0]          evt_dat,
   output logic                    sts_run,
   output logic [$clog2(STN)-1:0]  sts_stg,
   output logic [CNW-1:0]          sts_cnt,
   output logic                    trg_hit,
   output logic                    trg_done
);

   localparam int c_STW = $clog2(STN);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           r_state;
   logic [c_STW-1:0] r_stg;
   logic [CNW-1:0]   r_cnt;
   logic             r_hit;
   logic             r_done;

   state_t           w_state_nxt;
   logic [c_STW-1:0] w_stg_nxt;
   logic [CNW-1:0]   w_cnt_nxt;
   logic             w_hit_nxt;
   logic             w_done_nxt;

   // ------------------------------------------------------------------
   // Current-stage configuration mux
   // ------------------------------------------------------------------
   logic [CMN-1:0]   w_msk;
   logic             w_mod;
   logic [CNW-1:0]   w_cnt_cfg;
   logic [CNW-1:0]   w_need;
   logic             w_last;
   logic             w_match;
   logic [CNW:0]     w_cnt_inc;
   logic             w_stage_full;

   assign w_msk     = cfg_msk[int'(r_stg)*CMN +: CMN];
   assign w_mod     = cfg_mod[r_stg];
   assign w_cnt_cfg = cfg_cnt[int'(r_stg)*CNW +: CNW];
   assign w_need    = CNW'(max1(32'(w_cnt_cfg)));
   assign w_last    = cfg_lst[r_stg] | (r_stg == c_STW'(STN - 1));

   // One extra bit so cnt+1 cannot wrap before the comparison, even if
   // the count config was lowered under a running sequence.
   assign w_cnt_inc    = {1'b0, r_cnt} + {{CNW{1'b0}}, 1'b1};
   assign w_stage_full = (w_cnt_inc >= {1'b0, w_need});

   trigger_stage_match #(
      .CMN (CMN)
   ) u_match (
      .msk   (w_msk),
      .mod   (w_mod),
      .evt   (evt_dat),
      .match (w_match)
   );

`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
   // ------------------------------------------------------------------
   // Stage timeout: counts valid samples spent in stages 1 and above
   // ------------------------------------------------------------------
   logic [CNW-1:0]   r_tmo_cnt;
   logic             r_tmo_pls;
   logic [CNW-1:0]   w_tmo_cnt_nxt;
   logic             w_tmo_pls_nxt;
   logic [CNW-1:0]   w_tmo_cfg;
   logic [CNW:0]     w_tmo_inc;
   logic             w_tmo_hit;

   assign w_tmo_cfg = cfg_tmo[int'(r_stg)*CNW +: CNW];
   assign w_tmo_inc = {1'b0, r_tmo_cnt} + {{CNW{1'b0}}, 1'b1};
   // Fires on the sample that brings the count up to the programmed limit;
   // >= keeps a stuck stage recoverable if the limit is lowered mid-run.
   assign w_tmo_hit = (r_stg != '0) && (w_tmo_cfg != '0) &&
                      (w_tmo_inc >= {1'b0, w_tmo_cfg});
   assign sts_tmo   = r_tmo_pls;
`endif

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_stg_nxt   = r_stg;
      w_cnt_nxt   = r_cnt;
      w_hit_nxt   = 1'b0;
      w_done_nxt  = r_done;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      w_tmo_cnt_nxt = r_tmo_cnt;
      w_tmo_pls_nxt = 1'b0;
`endif

      if (ctl_abort) begin
         // Abort beats arm; trg_done is left as it was.
         w_state_nxt = IDLE;
         w_stg_nxt   = '0;
         w_cnt_nxt   = '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
         w_tmo_cnt_nxt = '0;
`endif
      end else if (ctl_arm) begin
         // (Re)start from any state; an event in this cycle is ignored.
         w_state_nxt = RUN;
         w_stg_nxt   = '0;
         w_cnt_nxt   = '0;
         w_done_nxt  = 1'b0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
         w_tmo_cnt_nxt = '0;
`endif
      end else if ((r_state == RUN) && evt_vld) begin
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
         // Saturate rather than wrap so a disabled timeout never re-arms.
         if ((r_stg != '0) && (r_tmo_cnt != '1)) begin
            w_tmo_cnt_nxt = w_tmo_inc[CNW-1:0];
         end
`endif
         if (w_match) begin
            if (w_stage_full) begin
               w_cnt_nxt = '0;
               if (w_last) begin
                  w_state_nxt = DONE;
                  w_hit_nxt   = 1'b1;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_stg_nxt = r_stg + c_STW'(1);
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
                  w_tmo_cnt_nxt = '0;
`endif
               end
            end else begin
               w_cnt_nxt = w_cnt_inc[CNW-1:0];
            end
         end
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
         else if (w_tmo_hit) begin
            // Fall back to stage 0 but stay running.
            w_stg_nxt     = '0;
            w_cnt_nxt     = '0;
            w_tmo_cnt_nxt = '0;
            w_tmo_pls_nxt = 1'b1;
         end
`endif
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_stg   <= '0;
         r_cnt   <= '0;
         r_hit   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_stg   <= w_stg_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hit   <= w_hit_nxt;
         r_done  <= w_done_nxt;
      end
   end

`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
         r_tmo_pls <= 1'b0;
      end else begin
         r_tmo_cnt <= w_tmo_cnt_nxt;
         r_tmo_pls <= w_tmo_pls_nxt;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign sts_run  = (r_state == RUN);
   assign sts_stg  = r_stg;
   assign sts_cnt  = r_cnt;
   assign trg_hit  = r_hit;
   assign trg_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_trigger_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trigger_sequencer
//  Description : Self-checking bench for trigger_sequencer (STN=4, CMN=4,
//                CNW=16). A table of directed vectors walks a three-stage
//                sequence; hand-written sequences cover single-stage
//                trigger, AND mode, empty mask, arm/abort interplay, async
//                reset and (when enabled) the stage timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trigger_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        ctl_arm;
   logic        ctl_abort;
   logic [15:0] cfg_msk;
   logic [3:0]  cfg_mod;
   logic [63:0] cfg_cnt;
   logic [3:0]  cfg_lst;
   logic        evt_vld;
   logic [3:0]  evt_dat;
   logic        sts_run;
   logic [1:0]  sts_stg;
   logic [15:0] sts_cnt;
   logic        trg_hit;
   logic        trg_done;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
   logic [63:0] cfg_tmo;
   logic        sts_tmo;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   trigger_sequencer #(.STN(4), .CMN(4), .CNW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .ctl_arm   (ctl_arm),
      .ctl_abort (ctl_abort),
      .cfg_msk   (cfg_msk),
      .cfg_mod   (cfg_mod),
      .cfg_cnt   (cfg_cnt),
      .cfg_lst   (cfg_lst),
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      .cfg_tmo   (cfg_tmo),
      .sts_tmo   (sts_tmo),
`endif
      .evt_vld   (evt_vld),
      .evt_dat   (evt_dat),
      .sts_run   (sts_run),
      .sts_stg   (sts_stg),
      .sts_cnt   (sts_cnt),
      .trg_hit   (trg_hit),
      .trg_done  (trg_done)
   );

   typedef struct {
      logic       arm;
      logic       abt;
      logic       vld;
      logic [3:0] dat;
      logic       run;
      int         stg;
      int         cnt;
      logic       hit;
      logic       done;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic cyc(input logic a, input logic ab, input logic v,
                      input logic [3:0] d);
      ctl_arm   = a;
      ctl_abort = ab;
      evt_vld   = v;
      evt_dat   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic run, input int stg,
                          input int cnt, input logic hit, input logic done);
      chk({tag, ".run"},  int'(sts_run),  int'(run));
      chk({tag, ".stg"},  int'(sts_stg),  stg);
      chk({tag, ".cnt"},  int'(sts_cnt),  cnt);
      chk({tag, ".hit"},  int'(trg_hit),  int'(hit));
      chk({tag, ".done"}, int'(trg_done), int'(done));
   endtask

   // Three stages: counts 3,1,2; masks 0001,0010,0100; OR mode; stage 2 last
   task automatic cfg_three();
      cfg_msk = {4'b0000, 4'b0100, 4'b0010, 4'b0001};
      cfg_mod = 4'b0000;
      cfg_cnt = {16'd0, 16'd2, 16'd1, 16'd3};
      cfg_lst = 4'b0100;
   endtask

   initial begin
      rst = 1'b1;
      ctl_arm = 1'b0; ctl_abort = 1'b0; evt_vld = 1'b0; evt_dat = 4'h0;
      cfg_msk = '0; cfg_mod = '0; cfg_cnt = '0; cfg_lst = '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      cfg_tmo = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 1'b0, 0, 0, 1'b0, 1'b0);
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      chk("reset.tmo", int'(sts_tmo), 0);
`endif
      rst = 1'b0;
      cyc(0, 0, 0, 4'h0);
      chk_all("idle", 1'b0, 0, 0, 1'b0, 1'b0);

      // ---------------- single stage, OR, count 1 ----------------
      cfg_msk = 16'h0001; cfg_mod = 4'b0000;
      cfg_cnt = {48'd0, 16'd1}; cfg_lst = 4'b0001;
      cyc(1, 0, 0, 4'h0);
      chk_all("one.arm", 1'b1, 0, 0, 1'b0, 1'b0);
      cyc(0, 0, 1, 4'b0001);
      chk_all("one.hit", 1'b0, 0, 0, 1'b1, 1'b1);
      cyc(0, 0, 0, 4'h0);
      chk_all("one.after", 1'b0, 0, 0, 1'b0, 1'b1);
      cyc(0, 1, 0, 4'h0);
      chk_all("one.abort", 1'b0, 0, 0, 1'b0, 1'b1);

      // ---------------- table: three-stage sequence ----------------
      cfg_three();
      //           arm abt vld dat      run stg cnt hit done
      tbl[0]  = '{1'b1,1'b0,1'b0,4'b0000, 1'b1,0,0,1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b1,4'b0001, 1'b1,0,1,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b0,1'b1,4'b0010, 1'b1,0,1,1'b0,1'b0};
      tbl[3]  = '{1'b0,1'b0,1'b0,4'b0001, 1'b1,0,1,1'b0,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b1,4'b0001, 1'b1,0,2,1'b0,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b1,4'b0001, 1'b1,1,0,1'b0,1'b0};
      tbl[6]  = '{1'b0,1'b0,1'b1,4'b0001, 1'b1,1,0,1'b0,1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b1,4'b0010, 1'b1,2,0,1'b0,1'b0};
      tbl[8]  = '{1'b0,1'b0,1'b1,4'b1011, 1'b1,2,0,1'b0,1'b0};
      tbl[9]  = '{1'b0,1'b0,1'b1,4'b0100, 1'b1,2,1,1'b0,1'b0};
      tbl[10] = '{1'b0,1'b0,1'b1,4'b0100, 1'b0,2,0,1'b1,1'b1};
      tbl[11] = '{1'b0,1'b0,1'b1,4'b0100, 1'b0,2,0,1'b0,1'b1};
      tbl[12] = '{1'b1,1'b0,1'b0,4'b0000, 1'b1,0,0,1'b0,1'b0};
      tbl[13] = '{1'b0,1'b1,1'b0,4'b0000, 1'b0,0,0,1'b0,1'b0};
      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].arm, tbl[i].abt, tbl[i].vld, tbl[i].dat);
         chk_all($sformatf("tbl[%0d]", i), tbl[i].run, tbl[i].stg,
                 tbl[i].cnt, tbl[i].hit, tbl[i].done);
      end

      // ---------------- AND mode, mask 0110 ----------------
      cfg_msk = 16'h0006; cfg_mod = 4'b0001;
      cfg_cnt = {48'd0, 16'd1}; cfg_lst = 4'b0001;
      cyc(1, 0, 0, 4'h0);
      cyc(0, 0, 1, 4'b0010);
      chk_all("and.partial", 1'b1, 0, 0, 1'b0, 1'b0);
      cyc(0, 0, 1, 4'b0111);
      chk_all("and.full", 1'b0, 0, 0, 1'b1, 1'b1);
      cyc(0, 1, 0, 4'h0);

      // ---------------- empty mask never matches ----------------
      cfg_msk = 16'h0000; cfg_mod = 4'b0000;
      cyc(1, 0, 0, 4'h0);
      for (int i = 0; i < 20; i++) begin
         if (i == 10) cfg_mod = 4'b0001;
         cyc(0, 0, 1, 4'b1111);
         chk($sformatf("empty[%0d].stg", i), int'(sts_stg), 0);
         chk($sformatf("empty[%0d].hit", i), int'(trg_hit), 0);
      end
      chk("empty.run", int'(sts_run), 1);
      cyc(0, 1, 0, 4'h0);

      // ---------------- arm + abort same cycle ----------------
      cfg_three();
      cyc(1, 1, 0, 4'h0);
      chk_all("armabort", 1'b0, 0, 0, 1'b0, 1'b0);

      // ---------------- arm during RUN at stage 2 ----------------
      cyc(1, 0, 0, 4'h0);
      repeat (3) cyc(0, 0, 1, 4'b0001);
      cyc(0, 0, 1, 4'b0010);
      cyc(0, 0, 1, 4'b0100);
      chk_all("rearm.pre", 1'b1, 2, 1, 1'b0, 1'b0);
      cyc(1, 0, 1, 4'b0100);
      chk_all("rearm", 1'b1, 0, 0, 1'b0, 1'b0);
      cyc(0, 1, 0, 4'h0);

      // ---------------- async reset at stage 1 ----------------
      cyc(1, 0, 0, 4'h0);
      repeat (3) cyc(0, 0, 1, 4'b0001);
      chk("rst.pre.stg", int'(sts_stg), 1);
      evt_vld = 1'b1; evt_dat = 4'b0010;
      rst = 1'b1;
      #1;
      chk_all("rst.async", 1'b0, 0, 0, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst.hold.hit", int'(trg_hit), 0);
      end
      rst = 1'b0;
      cyc(0, 0, 1, 4'b0100);
      chk_all("rst.after", 1'b0, 0, 0, 1'b0, 1'b0);

`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      // ---------------- stage timeout ----------------
      cfg_tmo = {16'd0, 16'd0, 16'd5, 16'd0};
      cyc(1, 0, 0, 4'h0);
      repeat (3) cyc(0, 0, 1, 4'b0001);
      chk("tmo.reach.stg", int'(sts_stg), 1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 4'b0001);
         chk($sformatf("tmo.wait[%0d].stg", i), int'(sts_stg), 1);
         chk($sformatf("tmo.wait[%0d].tmo", i), int'(sts_tmo), 0);
      end
      cyc(0, 0, 1, 4'b0001);
      chk("tmo.fire.stg", int'(sts_stg), 0);
      chk("tmo.fire.tmo", int'(sts_tmo), 1);
      chk("tmo.fire.run", int'(sts_run), 1);
      cyc(0, 0, 0, 4'h0);
      chk("tmo.pulse.end", int'(sts_tmo), 0);
      repeat (3) cyc(0, 0, 1, 4'b0001);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4'b0001);
      cyc(0, 0, 1, 4'b0010);
      chk("tmo.match.stg", int'(sts_stg), 2);
      chk("tmo.match.tmo", int'(sts_tmo), 0);
      cyc(0, 1, 0, 4'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Multi-stage trigger controller for the logic-analyzer capture path.
- Consumes the per-sample event bits of a bank of trigger comparators, one bit per comparator.
- Walks a programmable sequence of up to STN stages. Each stage waits for a masked AND/OR combination of comparator events to occur a programmed number of times.
- On completion of the final stage, emits a single-cycle trigger pulse to the capture controller.

Parameters:
- STN, 4, number of sequencer stages (2..16)
- CMN, 4, number of comparator event inputs
- CNW, 16, occurrence-counter width per stage

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- ctl_arm  input  1  pulse: start or restart the sequence at stage 0
- ctl_abort  input  1  pulse: stop the sequence and return to idle
- cfg_msk  input  STN*CMN  per-stage event mask; stage s uses bits [s*CMN +: CMN]
- cfg_mod  input  STN  per-stage combine mode (0 = OR of masked events, 1 = AND of masked events)
- cfg_cnt  input  STN*CNW  per-stage required occurrence count; 0 is treated as 1
- cfg_lst  input  STN  per-stage last-stage flag
- evt_vld  input  1  event vector valid: the comparators updated for this sample
- evt_dat  input  CMN  comparator event bits (registered sts_evt of each comparator)
- sts_run  output  1  sequence running
- sts_stg  output  $clog2(STN)  current stage index
- sts_cnt  output  CNW  occurrences counted in the current stage
- trg_hit  output  1  one-cycle trigger pulse
- trg_done  output  1  sticky: trigger fired since the last arm

Behaviour:
- Reset values: state IDLE; sts_run=0, sts_stg=0, sts_cnt=0, trg_hit=0, trg_done=0.
- State IDLE:
  - ctl_arm -> RUN with stg=0, cnt=0, trg_done=0.
- State RUN:
  - Match is evaluated only on a cycle with evt_vld=1.
  - m = masked events, i.e. evt_dat & msk[stg].
  - match = mod[stg] ? (m == msk[stg]) : |m.
  - A stage with msk=0 never matches, in either mode.
  - On a match with cnt+1 < max(cnt_cfg[stg],1): cnt <= cnt+1.
  - On a match with cnt+1 >= max(cnt_cfg[stg],1):
    - if lst[stg]=1 or stg=STN-1 -> state DONE, trg_hit=1 on the next cycle, trg_done=1, cnt <= 0;
    - otherwise stg <= stg+1, cnt <= 0.
  - Event-to-trigger latency: trg_hit is high in the cycle after the clock edge that sampled the final matching evt_vld.
- State DONE:
  - trg_hit is high for exactly one cycle. sts_run=0. stg holds the final stage index.
  - ctl_arm -> RUN, same entry as from IDLE.
  - ctl_abort -> IDLE, trg_done retained.
- ctl_abort in any state -> IDLE: stg=0, cnt=0, trg_hit=0. trg_done is unchanged.
- ctl_arm while in RUN restarts at stage 0, cnt=0. Any evt_vld in that same cycle is ignored.
- ctl_arm and ctl_abort in the same cycle: abort wins.
- cnt never exceeds cnt_cfg-1. The counter never wraps.
- sts_run=1 exactly while in RUN.
- Config inputs are sampled live every cycle. Software changes them only while sts_run=0; changing them during RUN gives undefined sequencing but never a lock-up.
- rst asserted mid-sequence returns immediately to the reset values. No trg_hit is produced.

Optional Feature:
- Macro: TRIGGER_SEQUENCER_TIMEOUT_EN.
- When defined:
  - Extra input cfg_tmo [STN*CNW].
  - Per-stage timeout counter counts evt_vld samples spent in stages 1 and above.
  - Counter restarts on every stage advance.
  - When it reaches cfg_tmo[stg], with stg>0 and cfg_tmo[stg]!=0 (0 = no timeout): stg <= 0, cnt <= 0, sequence stays in RUN.
  - A match and a timeout in the same sample: the match wins.
  - Output sts_tmo pulses for one cycle per timeout.
- When undefined: the port, the counter and sts_tmo are absent; stages wait indefinitely.

Decomposition:
- Package trigger_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam STW = $clog2(STN);
  - a function max1(cnt) returning 1 for an input of 0, otherwise the input.
- Sub-module trigger_stage_match (combinational): msk, mod, evt -> match. Instantiated once, with a mux on stg.

Test Plan:
- Arm; stage 0 msk=4'b0001, mod=0, cnt=1, lst=1; one evt_vld with evt_dat=4'b0001 -> trg_hit exactly one cycle later, trg_done=1, sts_run=0.
- Three stages with cnt={3,1,2}, masks {0001,0010,0100}, mod=0, lst only on stage 2; feed the matching events -> sts_stg steps 0->1->2 after 3, 1 and 2 matches respectively; trg_hit after the 6th matching sample; non-matching samples in between leave cnt unchanged.
- mod=1, msk=4'b0110: evt_dat=0010 -> no advance; evt_dat=0111 -> match.
- msk=0000: 20 samples of evt_dat=1111 -> sts_stg stays 0, no trg_hit.
- Arm and abort in the same cycle -> state stays IDLE. Arm during RUN at stg=2 -> stg=0, cnt=0. Assert rst at stg=1 -> all outputs return to their reset values; no pulse.
- TIMEOUT_EN, cfg_tmo[1]=5: reach stage 1, then 5 non-matching samples -> sts_tmo pulse, stg=0. A matching event on the 5th sample instead -> advance to stage 2, no sts_tmo.
